// File: rtl/note_seq.sv
// note_seq: FIFO-backed note sequencer feeding beep's mode input.
// Entries play back-to-back, timed by the 10 ms tick from timer.
module note_seq #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        push,
    input  logic [15:0] pushdata,
    input  logic        flush,
    output logic [31:0] status,
    output logic [7:0]  mode
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [11:0] GAP_INIT = 12'(GAP_TICKS);

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [3:0]    note_r;
    logic [11:0]   dur_r;
    logic [11:0]   remaining;
    logic [11:0]   gap_cnt;

    logic empty;
    logic full;
    logic busy;
    logic push_ok;
    logic pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign busy    = (state != IDLE) || !empty;
    assign push_ok = push && !full && !flush;
    assign pop     = (state == IDLE) && !empty && !flush;

    // decoded purely from registers, so push never reaches status combinationally
    assign status = {23'h0, overflow, busy, full, empty, 5'(count)};

    function automatic logic [7:0] note_mode(input logic [3:0] n);
        return (n >= 4'd1 && n <= 4'd13) ? {4'h0, n} : 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= pushdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!push_ok && pop) begin
                count <= count - (AW + 1)'(1);
            end
            // a push into a full FIFO is lost even if a pop frees a slot
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode      <= 8'h00;
            note_r    <= '0;
            dur_r     <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            mode  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    mode <= 8'h00;
                    if (pop) begin
                        note_r <= mem[rptr][15:12];
                        dur_r  <= mem[rptr][11:0];
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (dur_r == 12'd0) begin
                        state <= IDLE;
                    end else begin
                        mode      <= note_mode(note_r);
                        remaining <= dur_r;
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        remaining <= remaining - 12'd1;
                        if (remaining == 12'd1) begin
                            mode <= 8'h00;
                            if (GAP_TICKS > 0) begin
                                gap_cnt <= GAP_INIT;
                                state   <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    mode <= 8'h00;
                    if (tick) begin
                        gap_cnt <= gap_cnt - 12'd1;
                        if (gap_cnt == 12'd1) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
